// File: rtl/tt_dgiota_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_dgiota_pkg
// Description : Shared types and constants for the dgiota phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_dgiota_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PCH     = 3'd1,
        SETTLE  = 3'd2,
        INT     = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    localparam logic [1:0] C_ADDR_PCH    = 2'd0;
    localparam logic [1:0] C_ADDR_SETTLE = 2'd1;
    localparam logic [1:0] C_ADDR_MAX    = 2'd2;
    localparam logic [1:0] C_ADDR_RSVD   = 2'd3;

    localparam int   C_PCH_LEN_DEF     = 4;
    localparam int   C_SETTLE_LEN_DEF  = 2;
    // Replicated across the full counter width to give an all-ones max count.
    localparam logic C_MAX_CNT_DEF_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tt_dgiota_sync.sv
`default_nettype none
// ============================================================================
// Module      : tt_dgiota_sync
// Description : Flop-chain synchronizer for the asynchronous comparator input.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_dgiota_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tt_dgiota_seq.sv
`default_nettype none
// ============================================================================
// Module      : tt_dgiota_seq
// Description : Precharge / settle / integrate / capture sequencer for the
//               dgiota single-slope converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_dgiota_seq
    import tt_dgiota_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             cmp_async,
    output logic             pch,
    output logic             int_en,
    output logic             smp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] C_MAX_CNT_DEF = {CNT_W{C_MAX_CNT_DEF_BIT}};

    state_t           r_state;
    logic [CNT_W-1:0] r_ph;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cfg_pch;
    logic [CNT_W-1:0] r_cfg_settle;
    logic [CNT_W-1:0] r_cfg_max;
    logic [CNT_W-1:0] r_pch_len;
    logic [CNT_W-1:0] r_settle_len;
    logic [CNT_W-1:0] r_max_cnt;
    logic             w_cmp_sync;
    logic [CNT_W-1:0] w_pch_eff;
    logic             w_at_max;

    tt_dgiota_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (cmp_async),
        .o_sync  (w_cmp_sync)
    );

    // A zero precharge length still yields one precharge cycle.
    assign w_pch_eff = (r_cfg_pch == '0) ? CNT_W'(1) : r_cfg_pch;
    assign w_at_max  = (r_cnt == r_max_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ph         <= '0;
            r_cnt        <= '0;
            r_cfg_pch    <= CNT_W'(C_PCH_LEN_DEF);
            r_cfg_settle <= CNT_W'(C_SETTLE_LEN_DEF);
            r_cfg_max    <= C_MAX_CNT_DEF;
            r_pch_len    <= CNT_W'(C_PCH_LEN_DEF);
            r_settle_len <= CNT_W'(C_SETTLE_LEN_DEF);
            r_max_cnt    <= C_MAX_CNT_DEF;
            pch          <= 1'b0;
            int_en       <= 1'b0;
            smp          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            ovf          <= 1'b0;
        end else begin
            case (cfg_addr)
                C_ADDR_PCH:    if (cfg_we) r_cfg_pch    <= cfg_data;
                C_ADDR_SETTLE: if (cfg_we) r_cfg_settle <= cfg_data;
                C_ADDR_MAX:    if (cfg_we) r_cfg_max    <= cfg_data;
                C_ADDR_RSVD:   ;
                default:       ;
            endcase

            smp  <= 1'b0;
            done <= 1'b0;

            if (!ena) begin
                r_state <= IDLE;
                pch     <= 1'b0;
                int_en  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, CAPTURE: begin
                        // Working copies are snapshotted here so mid-run writes wait.
                        if ((r_state == IDLE) ? start : cont) begin
                            r_state      <= PCH;
                            pch          <= 1'b1;
                            busy         <= 1'b1;
                            r_ph         <= CNT_W'(1);
                            r_pch_len    <= w_pch_eff;
                            r_settle_len <= r_cfg_settle;
                            r_max_cnt    <= r_cfg_max;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    PCH: begin
                        if (r_ph >= r_pch_len) begin
                            pch <= 1'b0;
                            if (r_settle_len == '0) begin
                                r_state <= INT;
                                int_en  <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= SETTLE;
                                r_ph    <= CNT_W'(1);
                            end
                        end else begin
                            r_ph <= r_ph + CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (r_ph >= r_settle_len) begin
                            r_state <= INT;
                            int_en  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_ph <= r_ph + CNT_W'(1);
                        end
                    end
                    INT: begin
                        if (w_cmp_sync || w_at_max) begin
                            r_state <= CAPTURE;
                            int_en  <= 1'b0;
                            smp     <= 1'b1;
                            done    <= 1'b1;
                            result  <= r_cnt;
                            ovf     <= w_at_max & ~w_cmp_sync;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        pch     <= 1'b0;
                        int_en  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_dgiota_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_dgiota_seq
// Description : Self-checking bench for tt_dgiota_seq with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_dgiota_seq;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             ena       = 1'b0;
    logic             start     = 1'b0;
    logic             cont      = 1'b0;
    logic             cfg_we    = 1'b0;
    logic [1:0]       cfg_addr  = 2'd0;
    logic [CNT_W-1:0] cfg_data  = '0;
    logic             cmp_async = 1'b0;
    logic             pch, int_en, smp, busy, done, ovf;
    logic [CNT_W-1:0] result;

    tt_dgiota_seq #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .cont      (cont),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cmp_async (cmp_async),
        .pch       (pch),
        .int_en    (int_en),
        .smp       (smp),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Timeline model: a conversion started at edge k precharges for P cycles,
    // settles S, integrates from edge I=k+P+S and captures at the first later
    // edge where the comparator seen SYNC edges ago was high or the count hit max.
    bit cmp_at [16384];
    bit m_active = 1'b0;
    bit m_ovf    = 1'b0;
    int m_k = 0, m_p = 1, m_i = 0, m_max = 0, m_cap = -1, m_result = 0;
    int cfg_pch = 4, cfg_set = 2, cfg_max = 255;
    int cnt_before;
    bit seen;

    int pch_run = 0, int_run = 0, gap_run = 0, done_cnt = 0;
    int last_pch_len = 0, last_int_len = 0, last_gap = -1;
    bit in_gap = 1'b0;

    task automatic begin_conv(input int k);
        m_active = 1'b1;
        m_k      = k;
        m_p      = (cfg_pch == 0) ? 1 : cfg_pch;
        m_i      = k + m_p + cfg_set;
        m_max    = cfg_max;
        m_cap    = -1;
    endtask

    always @(posedge clk) begin
        cmp_at[n] = rst ? 1'b0 : cmp_async;
        if (rst) begin
            m_active = 1'b0;
            m_cap    = -1;
            m_result = 0;
            m_ovf    = 1'b0;
            cfg_pch  = 4;
            cfg_set  = 2;
            cfg_max  = 255;
        end else begin
            if (m_active && !ena) begin
                m_active = 1'b0;
            end else if (m_active && m_cap >= 0 && n == m_cap + 1) begin
                if (cont) begin_conv(n);
                else m_active = 1'b0;
            end else if (m_active && m_cap < 0 && n > m_i) begin
                cnt_before = n - m_i - 1;
                seen       = (n >= SYNC) ? cmp_at[n - SYNC] : 1'b0;
                if (seen || cnt_before == m_max) begin
                    m_cap    = n;
                    m_result = cnt_before;
                    m_ovf    = (cnt_before == m_max) && !seen;
                end
            end else if (!m_active && start && ena) begin
                begin_conv(n);
            end
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: cfg_pch = int'(cfg_data);
                    2'd1: cfg_set = int'(cfg_data);
                    2'd2: cfg_max = int'(cfg_data);
                    default: ;
                endcase
            end
        end
        #1;
        check("pch",    pch,    int'(m_active && n >= m_k && n < m_k + m_p));
        check("int_en", int_en, int'(m_active && n >= m_i && m_cap < 0));
        check("smp",    smp,    int'(m_active && n == m_cap));
        check("done",   done,   int'(m_active && n == m_cap));
        check("busy",   busy,   int'(m_active));
        check("result", int'(result), m_result);
        check("ovf",    ovf,    int'(m_ovf));

        if (pch) pch_run++;
        else if (pch_run > 0) begin
            last_pch_len = pch_run;
            pch_run      = 0;
            in_gap       = 1'b1;
            gap_run      = 0;
        end
        if (in_gap) begin
            if (int_en) begin
                last_gap = gap_run;
                in_gap   = 1'b0;
            end else gap_run++;
        end
        if (int_en) int_run++;
        else if (int_run > 0) begin
            last_int_len = int_run;
            int_run      = 0;
        end
        if (done) done_cnt++;
        n++;
    end

    task automatic cfg_write(input logic [1:0] a, input int d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = CNT_W'(d);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // sel: 0 = int_en, 1 = smp
    task automatic wait_sig(input int sel, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = (sel == 0) ? int_en : smp;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got no pulse, required one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", int'(result), 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        ena = 1'b1;

        // Defaults, comparator forced high 10 cycles into INT
        done_cnt = 0;
        pulse_start();
        wait_sig(0, 50, "t1_int");
        repeat (10) @(negedge clk);
        cmp_async = 1'b1;
        wait_sig(1, 50, "t1_smp");
        check("t1_result", int'(result), 12);
        check("t1_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        cmp_async = 1'b0;
        check("t1_pch_len", last_pch_len, 4);
        check("t1_settle_gap", last_gap, 2);
        check("t1_done_pulses", done_cnt, 1);
        repeat (3) @(negedge clk);

        // Overflow at max_cnt = 5
        cfg_write(2, 5);
        pulse_start();
        wait_sig(1, 50, "t2_smp");
        check("t2_result", int'(result), 5);
        check("t2_ovf", ovf, 1);
        repeat (2) @(negedge clk);
        check("t2_int_len", last_int_len, 6);

        // Continuous mode with pch_len rewrite during INT
        cfg_write(2, 20);
        cont = 1'b1;
        pulse_start();
        wait_sig(0, 50, "t3_int");
        cfg_write(0, 7);
        wait_sig(1, 60, "t3_smp1");
        check("t3_first_pch_len", last_pch_len, 4);
        @(negedge clk);
        check("t3_pch_after_smp", pch, 1);
        cont = 1'b0;
        wait_sig(0, 50, "t3_int2");
        check("t3_second_pch_len", last_pch_len, 7);
        wait_sig(1, 60, "t3_smp2");
        repeat (3) @(negedge clk);
        cfg_write(0, 4);

        // Comparator trip exactly when count reaches max_cnt
        cfg_write(2, 8);
        pulse_start();
        wait_sig(0, 50, "t4_int");
        repeat (6) @(negedge clk);
        cmp_async = 1'b1;
        wait_sig(1, 50, "t4_smp");
        check("t4_result", int'(result), 8);
        check("t4_ovf", ovf, 0);
        @(negedge clk);
        cmp_async = 1'b0;
        repeat (4) @(negedge clk);

        // Drop ena in the first SETTLE cycle
        pulse_start();
        repeat (4) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_result_hold", int'(result), 8);
        ena = 1'b1;
        repeat (2) @(negedge clk);

        // start held high, no cont: back-to-back conversions
        cfg_write(2, 3);
        @(negedge clk);
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);

        // max_cnt = 0
        cfg_write(2, 0);
        pulse_start();
        wait_sig(1, 50, "t7_smp");
        check("t7_result", int'(result), 0);
        check("t7_ovf", ovf, 1);
        repeat (2) @(negedge clk);
        check("t7_int_len", last_int_len, 1);

        // pch_len = 0, settle_len = 0
        cfg_write(0, 0);
        cfg_write(1, 0);
        cfg_write(2, 3);
        pulse_start();
        wait_sig(1, 50, "t6_smp");
        repeat (2) @(negedge clk);
        check("t6_pch_len", last_pch_len, 1);
        check("t6_settle_gap", last_gap, 0);
        check("t6_result", int'(result), 3);
        check("t6_ovf", ovf, 1);

        // Reset mid-INT, then confirm config defaults are back
        cfg_write(2, 40);
        pulse_start();
        wait_sig(0, 50, "t8_int");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t8_rst_int_en", int_en, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_result", int'(result), 0);
        check("t8_rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        wait_sig(0, 50, "t8_int2");
        repeat (5) @(negedge clk);
        cmp_async = 1'b1;
        wait_sig(1, 50, "t8_smp");
        check("t8_result", int'(result), 7);
        check("t8_ovf", ovf, 0);
        @(negedge clk);
        cmp_async = 1'b0;
        check("t8_pch_len", last_pch_len, 4);
        check("t8_settle_gap", last_gap, 2);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
